adc_word_unpacker: RTL and testbench

- Receive end of the packed ADC sample format. Accepts 64-bit words holding four 14-bit samples in 16-bit lanes: lane0 = [13:0], lane1 = [29:16], lane2 = [45:32], lane3 = [61:48]. Pad bits are [15:14], [31:30], [47:46] and [63:62].
- Buffers up to two words and replays them as a 14-bit sample stream with valid/ready handshake, lane0 first.
- Sits between the ADC capture word path and downstream per-sample DSP, all in the i_62clk domain.

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_word_fifo.sv | 64 ++++++
 rtl/adc_word_unpacker.sv | 146 ++++++++++++++
 tb/tb_adc_word_unpacker.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and types for the packed ADC word format.
// Four 14-bit samples sit in 16-bit lanes; the top two bits of each lane are padding.
package adc_pkg;

  localparam int SAMPLE_W = 14;
  localparam int LANE_W   = 16;
  localparam int LANES    = 4;
  localparam int WORD_W   = LANE_W * LANES;

  localparam logic [WORD_W-1:0] PAD_MASK = 64'hC000_C000_C000_C000;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [2:0] {
    EMPTY,
    LANE0,
    LANE1,
    LANE2,
    LANE3
  } unpack_state_t;

  function automatic logic has_pad_bits(input logic [WORD_W-1:0] word);
    return |(word & PAD_MASK);
  endfunction

endpackage

// File: rtl/adc_word_fifo.sv
// Small synchronous word FIFO; head is a registered entry selected by the registered read pointer,
// so it is valid as soon as the FIFO is non-empty.
module adc_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       i_62clk,
  input  logic                       i_nreset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] COUNT_ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_reg != COUNT_FULL);
  assign do_pop  = pop && (count_reg != COUNT_ZERO);

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge i_62clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == COUNT_FULL);
  assign empty = (count_reg == COUNT_ZERO);
  assign count = count_reg;

endmodule

// File: rtl/adc_word_unpacker.sv
// Buffers packed 4-sample ADC words and replays them as a 14-bit sample stream, lane0 first.
// Also flags nonzero pad bits on accepted words and counts fully emitted words.
module adc_word_unpacker
  import adc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                i_62clk,
  input  logic                i_nreset,
  input  logic [WORD_W-1:0]   i_word,
  input  logic                i_word_valid,
  output logic                o_word_ready,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_valid,
  input  logic                i_sample_ready,
  output logic [1:0]          o_lane,
  output logic                o_pad_err,
  input  logic                i_clear_err,
  output logic [CNT_W-1:0]    o_word_count
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  unpack_state_t         state_reg;
  unpack_state_t         state_next;
  logic [WORD_W-1:0]     fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  push;
  logic                  pop;
  logic                  sample_valid;
  lane_idx_t             lane;
  logic [SAMPLE_W-1:0]   sample;
  logic [SAMPLE_W-1:0]   lane_sample [LANES];
  logic                  pad_err_reg;
  logic [CNT_W-1:0]      word_count_reg;

  // Ready depends only on registered occupancy, never on downstream ready.
  assign o_word_ready = !fifo_full;
  assign push         = i_word_valid && !fifo_full;

  adc_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_62clk   (i_62clk),
    .i_nreset  (i_nreset),
    .push      (push),
    .push_data (i_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_sample[gi] = fifo_head[gi*LANE_W +: SAMPLE_W];
  end

  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sample_valid = 1'b0;
    lane         = '0;
    pop          = 1'b0;
    sample       = '0;
    case (state_reg)
      EMPTY: begin
        if (!fifo_empty) begin
          state_next = LANE0;
        end
      end
      LANE0: begin
        sample_valid = 1'b1;
        lane         = 2'd0;
        if (i_sample_ready) begin
          state_next = LANE1;
        end
      end
      LANE1: begin
        sample_valid = 1'b1;
        lane         = 2'd1;
        if (i_sample_ready) begin
          state_next = LANE2;
        end
      end
      LANE2: begin
        sample_valid = 1'b1;
        lane         = 2'd2;
        if (i_sample_ready) begin
          state_next = LANE3;
        end
      end
      LANE3: begin
        sample_valid = 1'b1;
        lane         = 2'd3;
        if (i_sample_ready) begin
          pop = 1'b1;
          // Chain straight into the next buffered word so full-rate streams have no bubble.
          state_next = (fifo_count > FIFO_CNT_W'(1)) ? LANE0 : EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (sample_valid) begin
      sample = lane_sample[lane];
    end
  end

  assign o_sample_valid = sample_valid;
  assign o_sample       = sample;
  assign o_lane         = lane;

  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      pad_err_reg    <= 1'b0;
      word_count_reg <= '0;
    end else begin
      // A new pad violation takes priority over a simultaneous clear.
      if (push && has_pad_bits(i_word)) begin
        pad_err_reg <= 1'b1;
      end else if (i_clear_err) begin
        pad_err_reg <= 1'b0;
      end
      if (pop) begin
        word_count_reg <= word_count_reg + 1'b1;
      end
    end
  end

  assign o_pad_err    = pad_err_reg;
  assign o_word_count = word_count_reg;

endmodule

// File: tb/tb_adc_word_unpacker.sv
// Scoreboard bench for adc_word_unpacker: accepted words are expanded into expected samples,
// and a negedge monitor compares every sample transfer, the word counter and the pad flag.
module tb_adc_word_unpacker;

  localparam int TB_CNT_W = 8;

  logic                i_62clk = 1'b0;
  logic                i_nreset;
  logic [63:0]         i_word;
  logic                i_word_valid;
  logic                o_word_ready;
  logic [13:0]         o_sample;
  logic                o_sample_valid;
  logic                i_sample_ready;
  logic [1:0]          o_lane;
  logic                o_pad_err;
  logic                i_clear_err;
  logic [TB_CNT_W-1:0] o_word_count;

  always #8 i_62clk = ~i_62clk;

  // A narrow counter keeps the wrap test short.
  adc_word_unpacker #(
    .FIFO_DEPTH (2),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .i_62clk        (i_62clk),
    .i_nreset       (i_nreset),
    .i_word         (i_word),
    .i_word_valid   (i_word_valid),
    .o_word_ready   (o_word_ready),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .i_sample_ready (i_sample_ready),
    .o_lane         (o_lane),
    .o_pad_err      (o_pad_err),
    .i_clear_err    (i_clear_err),
    .o_word_count   (o_word_count)
  );

  typedef struct {
    logic [13:0] sample;
    logic [1:0]  lane;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  bit          exp_pad = 1'b0;
  bit          hold_pending = 1'b0;
  logic [13:0] hold_sample;
  logic [1:0]  hold_lane;
  bit          gap_watch = 1'b0;
  bit          seen_valid = 1'b0;
  int          gaps = 0;
  bit          rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] rand_word(input bit padded);
    logic [63:0] w;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      w[16*l +: 14] = 14'($urandom_range(16383, 0));
      if (padded) w[16*l+14 +: 2] = 2'($urandom_range(3, 0));
    end
    return w;
  endfunction

  // Monitor / scoreboard: values are sampled mid-cycle, so they describe what the next edge does.
  always @(negedge i_62clk) begin
    if (!i_nreset) begin
      exp_q.delete();
      exp_count    = 0;
      exp_pad      = 1'b0;
      hold_pending = 1'b0;
    end else begin
      check("word_count", 64'(o_word_count), 64'(exp_count));
      check("pad_err", 64'(o_pad_err), 64'(exp_pad));
      if (hold_pending) begin
        check("hold_valid", 64'(o_sample_valid), 64'd1);
        check("hold_sample", {48'd0, o_lane, o_sample}, {48'd0, hold_lane, hold_sample});
      end
      hold_pending = o_sample_valid && !i_sample_ready;
      hold_sample  = o_sample;
      hold_lane    = o_lane;
      if (gap_watch) begin
        if (o_sample_valid) seen_valid = 1'b1;
        else if (seen_valid && exp_q.size() > 0) gaps++;
      end
      if (o_sample_valid && i_sample_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got %0h lane %0d, expected no sample", o_sample, o_lane);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (o_sample !== e.sample || o_lane !== e.lane) begin
            errors++;
            $display("FAIL sample: got %0h lane %0d, expected %0h lane %0d",
                     o_sample, o_lane, e.sample, e.lane);
          end
          if (e.lane == 2'd3) exp_count = (exp_count + 1) % (1 << TB_CNT_W);
        end
      end
      if (i_word_valid && o_word_ready) begin
        for (int l = 0; l < 4; l++) begin
          exp_t e;
          e.sample = 14'((i_word >> (16 * l)) & 64'h3FFF);
          e.lane   = 2'(l);
          exp_q.push_back(e);
        end
        if ((i_word[15:14] | i_word[31:30] | i_word[47:46] | i_word[63:62]) != 2'b00) exp_pad = 1'b1;
        else if (i_clear_err) exp_pad = 1'b0;
      end else if (i_clear_err) begin
        exp_pad = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [63:0] w);
    bit accepted;
    int n;
    accepted     = 1'b0;
    n            = 0;
    i_word       = w;
    i_word_valid = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge i_62clk);
      accepted = o_word_ready;
      @(posedge i_62clk);
      #1;
      n++;
    end
    i_word_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, expected o_word_ready", n);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge i_62clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d samples outstanding, expected 0", exp_q.size());
    end
    @(posedge i_62clk);
    #1;
  endtask

  task automatic wait_valid_lane(input logic [1:0] want);
    int n;
    n = 0;
    @(negedge i_62clk);
    while (!(o_sample_valid && o_lane == want) && n < 100) begin
      @(negedge i_62clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_lane: got no valid lane %0d, expected it within 100 cycles", want);
    end
  endtask

  initial begin
    i_nreset       = 1'b0;
    i_word         = '0;
    i_word_valid   = 1'b0;
    i_sample_ready = 1'b0;
    i_clear_err    = 1'b0;
    repeat (3) @(posedge i_62clk);
    #1;
    check("rst_valid", 64'(o_sample_valid), 64'd0);
    check("rst_sample", 64'(o_sample), 64'd0);
    check("rst_lane", 64'(o_lane), 64'd0);
    check("rst_ready", 64'(o_word_ready), 64'd1);
    check("rst_pad", 64'(o_pad_err), 64'd0);
    check("rst_count", 64'(o_word_count), 64'd0);
    i_nreset = 1'b1;
    @(posedge i_62clk);
    #1;

    // Basic word at full downstream rate, with latency check.
    i_sample_ready = 1'b1;
    send_word(64'h3FFF_0000_1555_2ABC);
    @(negedge i_62clk);
    check("lat_idle", 64'(o_sample_valid), 64'd0);
    @(negedge i_62clk);
    check("lat_valid", 64'(o_sample_valid), 64'd1);
    check("lat_sample", 64'(o_sample), 64'h2ABC);
    drain(50);
    check("count_one", 64'(o_word_count), 64'd1);

    // Backpressure while presenting lane1.
    i_sample_ready = 1'b0;
    send_word(64'h3FFF_0000_1555_2ABC);
    wait_valid_lane(2'd0);
    @(posedge i_62clk);
    #1;
    i_sample_ready = 1'b1;
    @(posedge i_62clk);
    #1;
    i_sample_ready = 1'b0;
    repeat (3) @(posedge i_62clk);
    @(negedge i_62clk);
    check("stall_sample", 64'(o_sample), 64'h1555);
    check("stall_lane", 64'(o_lane), 64'd1);
    @(posedge i_62clk);
    #1;
    i_sample_ready = 1'b1;
    drain(50);

    // Three words offered while downstream is stalled.
    i_sample_ready = 1'b0;
    fork
      begin
        send_word(rand_word(1'b0));
        send_word(rand_word(1'b0));
        send_word(rand_word(1'b0));
      end
      begin
        repeat (6) @(negedge i_62clk);
        check("full_not_ready", 64'(o_word_ready), 64'd0);
        @(posedge i_62clk);
        #1;
        gaps       = 0;
        seen_valid = 1'b0;
        gap_watch  = 1'b1;
        i_sample_ready = 1'b1;
      end
    join
    drain(100);
    gap_watch = 1'b0;
    check("three_word_gaps", 64'(gaps), 64'd0);

    // Pad flag: set, clear alone, then set wins over a coincident clear.
    send_word(64'h0000_0000_0000_C001);
    @(negedge i_62clk);
    check("pad_set", 64'(o_pad_err), 64'd1);
    drain(50);
    i_clear_err = 1'b1;
    @(posedge i_62clk);
    #1;
    i_clear_err = 1'b0;
    @(negedge i_62clk);
    check("pad_cleared", 64'(o_pad_err), 64'd0);
    @(posedge i_62clk);
    #1;
    i_clear_err = 1'b1;
    send_word(64'h8000_0000_0000_0123);
    i_clear_err = 1'b0;
    @(negedge i_62clk);
    check("pad_set_wins", 64'(o_pad_err), 64'd1);
    drain(50);

    // Reset in the middle of a word.
    send_word(rand_word(1'b0));
    wait_valid_lane(2'd1);
    @(posedge i_62clk);
    #3;
    i_nreset = 1'b0;
    #1;
    check("midrst_valid", 64'(o_sample_valid), 64'd0);
    check("midrst_count", 64'(o_word_count), 64'd0);
    check("midrst_ready", 64'(o_word_ready), 64'd1);
    @(posedge i_62clk);
    #1;
    i_nreset = 1'b1;
    send_word(rand_word(1'b0));
    drain(50);

    // Randomized traffic with random backpressure and clears.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(2, 0)) @(posedge i_62clk);
          #1;
          send_word(rand_word($urandom_range(7, 0) == 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_62clk);
          #1;
          i_sample_ready = ($urandom_range(3, 0) != 0);
          i_clear_err    = ($urandom_range(15, 0) == 0);
        end
      end
    join
    i_sample_ready = 1'b1;
    i_clear_err    = 1'b0;
    drain(400);

    // Full-rate stream long enough to wrap the word counter.
    gaps       = 0;
    seen_valid = 1'b0;
    gap_watch  = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send_word(rand_word(1'b0));
    end
    drain(100);
    gap_watch = 1'b0;
    check("stream_gaps", 64'(gaps), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
